// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - flash window map, arbiter state encoding and port ids
package mem_map_pkg;

  localparam logic [31:0] FLASH_BASE  = 32'h0800_0000;
  localparam int          FLASH_DEPTH = 8;
  localparam int          FLASH_IDX_W = $clog2(FLASH_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef logic port_id_t;
  localparam port_id_t PORT_FETCH = 1'b0;
  localparam port_id_t PORT_DATA  = 1'b1;

endpackage

// File: rtl/rom_addr_decode.sv
// rtl/rom_addr_decode.sv - byte address to flash word index plus fault flag
module rom_addr_decode
  import mem_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = FLASH_BASE,
  parameter int          DEPTH     = FLASH_DEPTH,
  parameter int          IDX_W     = FLASH_IDX_W
) (
  input  logic [31:0]      i_addr,
  output logic [IDX_W-1:0] o_index,
  output logic             o_fault
);

  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic [31:0] w_off;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and
  // therefore fall out of range without a separate lower-bound compare.
  assign w_off   = i_addr - BASE_ADDR;
  assign o_fault = (w_off >= LIMIT) || (i_addr[1:0] != 2'b00);
  assign o_index = w_off[IDX_W+1:2];

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin fetch/data arbiter for the single-port flash
module rom_arbiter
  import mem_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = FLASH_BASE,
  parameter int          DEPTH     = FLASH_DEPTH,
  parameter int          IDX_W     = FLASH_IDX_W
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  port_id_t         r_last_grant;
  port_id_t         r_winner;
  port_id_t         w_winner;
  logic             r_we;
  logic             r_fault;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             w_grant;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_d_idx;
  logic             w_if_fault;
  logic             w_d_fault;
  logic             w_rd_ok;

  rom_addr_decode #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W)
  ) u_if_decode (
    .i_addr (if_addr),
    .o_index(w_if_idx),
    .o_fault(w_if_fault)
  );

  rom_addr_decode #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W)
  ) u_d_decode (
    .i_addr (d_addr),
    .o_index(w_d_idx),
    .o_fault(w_d_fault)
  );

  // The memory port holds the latched command outside ISSUE; only mem_we is gated.
  assign mem_addr  = {{(32-IDX_W){1'b0}}, r_idx};
  assign mem_wdata = r_wdata;
  assign w_rd_ok   = !r_we && !r_fault;

  // Round-robin choice: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_winner = PORT_FETCH;
    if (if_req && d_req) begin
      w_winner = (r_last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (d_req) begin
      w_winner = PORT_DATA;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and all handshake/response outputs; grants are gated by reset_n
  // so nothing leaks out while reset is held with requests pending.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = 32'h0;
    if_fault     = 1'b0;
    d_rvalid     = 1'b0;
    d_rdata      = 32'h0;
    d_fault      = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((if_req || d_req) && reset_n) begin
          w_grant      = 1'b1;
          if_gnt       = (w_winner == PORT_FETCH);
          d_gnt        = (w_winner == PORT_DATA);
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_we       = r_we && !r_fault;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (r_winner == PORT_FETCH) begin
          if_rvalid = 1'b1;
          if_fault  = r_fault;
          if_rdata  = w_rd_ok ? mem_rdata : 32'h0;
        end else begin
          d_rvalid = 1'b1;
          d_fault  = r_fault;
          d_rdata  = w_rd_ok ? mem_rdata : 32'h0;
        end
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the pre-decoded command of the winning port at the grant edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= PORT_FETCH;
      r_winner     <= PORT_FETCH;
      r_we         <= 1'b0;
      r_fault      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 32'h0;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
      r_winner     <= w_winner;
      if (w_winner == PORT_DATA) begin
        r_we    <= d_we;
        r_fault <= w_d_fault;
        r_idx   <= w_d_idx;
        r_wdata <= d_wdata;
      end else begin
        r_we    <= 1'b0;
        r_fault <= w_if_fault;
        r_idx   <= w_if_idx;
        r_wdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;
  import mem_map_pkg::*;

  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        preload;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycle count, cycle of the last grant, last winner, pending access.
  int       cyc   = 0;
  int       g_cyc = -100;
  port_id_t m_last = PORT_FETCH;
  logic     t_live = 1'b0;
  port_id_t t_port;
  logic     t_we, t_fault;
  int       t_idx;
  logic [31:0] t_wdata;

  always #5 clock = ~clock;

  rom_arbiter #(
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH),
    .IDX_W    (3)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_fault (if_fault),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_fault  (d_fault),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory: data_out is valid the cycle after sampling.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0000_3000 + 32'(i);
    end else begin
      if (mem_we) mem[mem_addr[2:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[2:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'(4 * DEPTH)) || (a % 4 != 0);
  endfunction

  function automatic int exp_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) / 4;
    return int'(w % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)  return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (r == 7) return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    if (r == 8) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
    return BASE - 32'(4 * $urandom_range(1, 3));
  endfunction

  task automatic check_idle_resp();
    check("if_rvalid", 32'(if_rvalid), 32'h0);
    check("if_rdata",  if_rdata,       32'h0);
    check("if_fault",  32'(if_fault),  32'h0);
    check("d_rvalid",  32'(d_rvalid),  32'h0);
    check("d_rdata",   d_rdata,        32'h0);
    check("d_fault",   32'(d_fault),   32'h0);
  endtask

  // One clock of stimulus: check the cycle at the falling edge, then advance the model.
  task automatic tick();
    logic        eg_if, eg_d;
    port_id_t    win;
    logic [31:0] er, a;
    eg_if = 1'b0;
    eg_d  = 1'b0;
    win   = PORT_FETCH;
    @(negedge clock);
    if (!reset_n) begin
      check("rst_if_gnt",    32'(if_gnt), 32'h0);
      check("rst_d_gnt",     32'(d_gnt),  32'h0);
      check("rst_mem_we",    32'(mem_we), 32'h0);
      check("rst_mem_addr",  mem_addr,    32'h0);
      check("rst_mem_wdata", mem_wdata,   32'h0);
      check_idle_resp();
      g_cyc  = -100;
      m_last = PORT_FETCH;
      t_live = 1'b0;
    end else begin
      if ((cyc - g_cyc >= 3) && (if_req || d_req)) begin
        if (if_req && d_req) win = !m_last;
        else                 win = d_req ? PORT_DATA : PORT_FETCH;
        eg_if = (win == PORT_FETCH);
        eg_d  = (win == PORT_DATA);
      end
      check("if_gnt", 32'(if_gnt), 32'(eg_if));
      check("d_gnt",  32'(d_gnt),  32'(eg_d));
      if (t_live && cyc == g_cyc + 1) begin
        check("issue_mem_we",   32'(mem_we), 32'(t_we && !t_fault));
        check("issue_mem_addr", mem_addr,    32'(t_idx));
        if (t_we && !t_fault) begin
          check("issue_mem_wdata", mem_wdata, t_wdata);
          ref_mem[t_idx] = t_wdata;
        end
      end else begin
        check("mem_we", 32'(mem_we), 32'h0);
      end
      if (t_live && cyc == g_cyc + 2) begin
        er = (t_we || t_fault) ? 32'h0 : ref_mem[t_idx];
        check("if_rvalid", 32'(if_rvalid), 32'(t_port == PORT_FETCH));
        check("d_rvalid",  32'(d_rvalid),  32'(t_port == PORT_DATA));
        check("if_rdata",  if_rdata, (t_port == PORT_FETCH) ? er : 32'h0);
        check("d_rdata",   d_rdata,  (t_port == PORT_DATA)  ? er : 32'h0);
        check("if_fault",  32'(if_fault), 32'(t_port == PORT_FETCH && t_fault));
        check("d_fault",   32'(d_fault),  32'(t_port == PORT_DATA && t_fault));
        t_live = 1'b0;
      end else begin
        check_idle_resp();
      end
      if (eg_if || eg_d) begin
        a       = eg_d ? d_addr : if_addr;
        t_port  = win;
        t_we    = eg_d ? d_we : 1'b0;
        t_wdata = d_wdata;
        t_fault = exp_fault(a);
        t_idx   = exp_idx(a);
        t_live  = 1'b1;
        g_cyc   = cyc;
        m_last  = win;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (eg_if) if_req = 1'b0;
    if (eg_d)  d_req  = 1'b0;
  endtask

  task automatic set_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
  endtask

  // Run until every raised request has been granted, then let the last access finish.
  task automatic serve();
    for (int i = 0; i < 20 && (if_req || d_req); i++) tick();
    check("grant_timeout", 32'(if_req || d_req), 32'h0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic run_random(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      if (!if_req && $urandom_range(0, 99) < pct) set_if(rand_addr());
      if (!d_req && $urandom_range(0, 99) < pct)
        set_d(1'($urandom_range(0, 1)), rand_addr(), $urandom());
      tick();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0000_3000 + 32'(i);
    preload = 1'b1;
    reset_n = 1'b0;
    d_we    = 1'b0;
    d_wdata = 32'h0;
    set_if(BASE + 32'h4);
    set_d(1'b0, BASE, 32'h0);
    @(posedge clock);
    #1;
    preload = 1'b0;

    // Reset held with both requests up, then release: data wins the first tie.
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    serve();

    // Fetch read of word 1.
    set_if(BASE + 32'h4);
    serve();

    // Continuous contention.
    run_random(14, 100);

    // Write then read back.
    set_d(1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
    serve();
    set_d(1'b0, BASE + 32'h8, 32'h0);
    serve();

    // Faulting accesses.
    set_d(1'b1, BASE + 32'h20, 32'h1234_5678);
    serve();
    set_d(1'b0, BASE + 32'h2, 32'h0);
    serve();
    set_if(32'h07FF_FFFC);
    serve();

    // Reset dropped during the ISSUE cycle of a write.
    set_d(1'b1, BASE + 32'hC, 32'hBAD0_0001);
    tick();
    reset_n = 1'b0;
    #1;
    check("rstmid_mem_we", 32'(mem_we), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    set_d(1'b0, BASE + 32'hC, 32'h0);
    serve();

    // Randomized traffic.
    run_random(300, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
